hawk_tbl_wr_mngr: RTL
=====================

// Module: hawk_tbl_wr_mngr
// PURPOSE
// - Write-side counterpart of the hawk table read path: writes updated ATT/TOL entries back to DRAM.
// - Takes a 64B table cacheline previously fetched by the read manager plus one new entry.
// - Merges the entry into its slot and issues one single-beat AXI4 write (AW/W/B).
// - Sits between hawk_pgrd_mngr/hawk_cmpresn_mngr (requesters) and the hacd AXI master mux.
// PARAMETERS
// - AXI_ID      default 4'h2  AWID driven on every write
// - ID_W        default 4     AXI ID width
// - B_TIMEOUT   default 1024  cycles allowed from last AW/W handshake to BVALID before error
// PORTS
// - clk_i         in   1    clock
// - rst_i         in   1    synchronous, active-high reset
// - req_vld_i     in   1    write request valid
// - req_rdy_o     out  1    request accepted when req_vld_i & req_rdy_o
// - req_type_i    in   1    0=ATT update, 1=TOL (list) update
// - att_id_i      in   clogb2(ATT_ENTRY_MAX)   ATT entry id, 1-based
// - lst_id_i      in   clogb2(LST_ENTRY_MAX)   list entry id, 1-based
// - line_i        in   `HACD_AXI4_DATA_WIDTH   original cacheline contents
// - att_entry_i   in   64   new AttEntry (used when req_type_i=0)
// - lst_entry_i   in   128  new ListEntry (used when req_type_i=1)
// - awid_o/awaddr_o/awlen_o/awsize_o/awburst_o/awvalid_o out; awready_i in   AXI4 AW
// - wdata_o/wstrb_o/wlast_o/wvalid_o out; wready_i in                       AXI4 W
// - bid_i/bresp_i/bvalid_i in; bready_o out                                 AXI4 B
// - done_o        out  1    one-cycle pulse: write completed (OK or error)
// - err_o         out  1    sticky: SLVERR/DECERR or B timeout; cleared by reset only
// BEHAVIOUR
// - Reset: state IDLE; req_rdy_o=1; awvalid_o=wvalid_o=bready_o=0; done_o=0; err_o=0; timer=0.
// - Address (full-width math, truncated to `HACD_AXI4_ADDR_WIDTH):
//   ATT: HAWK_ATT_START + (((att_id_i-1)>>3)<<6), slot s=(att_id_i-1)[2:0], bits [64*s+:64].
//   TOL: HAWK_LIST_START + (((lst_id_i-1)>>2)<<6), slot s=(lst_id_i-1)[1:0], bits [128*s+:128].
//   Id 0 wraps: ATT slot 7, TOL slot 3 (matches read-side decode). Other slots copied unchanged.
// - Fixed AXI fields: awlen=0, awsize=3'd6, awburst=INCR, wstrb=all ones, wlast=1, awid=AXI_ID.
// - FSM: IDLE -> SEND -> WAIT_B -> DONE -> IDLE.
//   IDLE: req_rdy_o=1; on accept register addr and merged line (1 cycle), go SEND; req_rdy_o=0 after.
//   SEND: awvalid_o and wvalid_o asserted together next cycle; each drops independently on its
//         own handshake (either order, or same cycle); payload stable while valid. Both done -> WAIT_B.
//   WAIT_B: bready_o=1; timer counts from 0. bvalid_i -> DONE; bresp_i!=OKAY sets err_o.
//         timer==B_TIMEOUT-1 without bvalid -> err_o=1, DONE (late B later is accepted and dropped
//         only while in WAIT_B; elsewhere bready_o=0).
//   DONE: done_o=1 for exactly one cycle; return to IDLE (next request accepted the cycle after).
// - Min latency accept->done_o: 4 cycles (AW/W ready and B returned in first possible cycles).
// - bid_i mismatching AXI_ID: sets err_o, still completes.
// - Reset mid-transaction: valids drop at next edge, in-flight write abandoned, no done_o.
// STRUCTURE
// - hawk_rd_pkg / hacd_pkg: AttEntry, ListEntry, HAWK_ATT_START, HAWK_LIST_START, entry maxima,
//   clogb2; add tbl_wr_reqpkt_t {type, ids, entry} and function merge_tbl_line() shared with read side.
// - One sub-module natural: hawk_axi_wr_single (AW/W/B single-beat handshake engine + timer);
//   top holds request register, address/merge logic, done/err.
// TESTING
// - ATT id 1, line=all 0xAA, entry=0x1122..88 -> awaddr=HAWK_ATT_START, wdata[63:0]=entry, rest 0xAA.
// - ATT id 16 -> awaddr=HAWK_ATT_START+0x40, slot 7 ([511:448]) replaced; TOL id 4 -> LIST_START, [511:384].
// - awready held 0 for 5 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held, payload stable.
// - bresp=2'b10 -> done_o pulses once, err_o=1 and stays 1 across subsequent OK writes.
// - No bvalid for B_TIMEOUT cycles -> err_o=1, done_o pulse, FSM in IDLE, req_rdy_o=1.
// - rst_i asserted while in WAIT_B -> next cycle all valids/bready 0, req_rdy_o=1, no done_o.

Source files
------------

// File: rtl/hawk_tbl_wr_mngr_pkg.sv
// hawk_tbl_wr_mngr_pkg: shared table geometry, write request packet and line merge/address helpers.
// The read-side decode and the write-back path both use these helpers, so slot placement stays identical.
package hawk_tbl_wr_mngr_pkg;
  localparam int unsigned AXI_DATA_W = 512;
  localparam int unsigned AXI_ADDR_W = 64;
  localparam int unsigned ATT_ENTRY_MAX = 1024;
  localparam int unsigned LST_ENTRY_MAX = 256;
  localparam int unsigned ATT_ID_W = $clog2(ATT_ENTRY_MAX);
  localparam int unsigned LST_ID_W = $clog2(LST_ENTRY_MAX);
  localparam logic [AXI_ADDR_W-1:0] HAWK_ATT_START = 64'h0000_0000_8000_0000;
  localparam logic [AXI_ADDR_W-1:0] HAWK_LIST_START = 64'h0000_0000_9000_0000;
  typedef logic [63:0] att_entry_t;
  typedef logic [127:0] lst_entry_t;
  typedef enum logic {TBL_ATT = 1'b0, TBL_TOL = 1'b1} tbl_type_e;
  typedef enum logic [1:0] {WR_IDLE, WR_SEND, WR_WAIT_B, WR_DONE} wr_state_e;
  typedef struct packed {
    tbl_type_e             typ;
    logic [ATT_ID_W-1:0]   att_id;
    logic [LST_ID_W-1:0]   lst_id;
    att_entry_t            att_entry;
    lst_entry_t            lst_entry;
  } tbl_wr_reqpkt_t;
  // Ids are 1-based; the decrement wraps inside the id width, so id 0 lands in the last slot of the last line.
  function automatic logic [AXI_ADDR_W-1:0] tbl_line_addr(input tbl_wr_reqpkt_t p);
    logic [ATT_ID_W-1:0] a;
    logic [LST_ID_W-1:0] l;
    a = p.att_id - ATT_ID_W'(1);
    l = p.lst_id - LST_ID_W'(1);
    return p.typ == TBL_ATT ? HAWK_ATT_START + (AXI_ADDR_W'(a >> 3) << 6)
                            : HAWK_LIST_START + (AXI_ADDR_W'(l >> 2) << 6);
  endfunction
  function automatic logic [AXI_DATA_W-1:0] merge_tbl_line(input logic [AXI_DATA_W-1:0] line,
                                                           input tbl_wr_reqpkt_t p);
    logic [AXI_DATA_W-1:0] m;
    logic [ATT_ID_W-1:0] a;
    logic [LST_ID_W-1:0] l;
    m = line;
    a = p.att_id - ATT_ID_W'(1);
    l = p.lst_id - LST_ID_W'(1);
    if (p.typ == TBL_ATT) m[{a[2:0], 6'b0} +: 64] = p.att_entry;
    else m[{l[1:0], 7'b0} +: 128] = p.lst_entry;
    return m;
  endfunction
endpackage

// File: rtl/hawk_tbl_wr_mngr_axi_wr.sv
// hawk_axi_wr_single: single-beat AXI4 write handshake engine with B-response timeout.
// start_i launches AW+W together; idle_o/done_o expose the FSM; err_o is a one-cycle error event
// (bad BRESP, unexpected BID or no B within B_TIMEOUT cycles). Payload is held by the parent.
module hawk_axi_wr_single
  import hawk_tbl_wr_mngr_pkg::*;
#(
  parameter int unsigned     ID_W      = 4,
  parameter logic [ID_W-1:0] AXI_ID    = ID_W'('h2),
  parameter int unsigned     B_TIMEOUT = 1024
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  output logic            idle_o,
  output logic            done_o,
  output logic            err_o,
  output logic            awvalid_o,
  input  logic            awready_i,
  output logic            wvalid_o,
  input  logic            wready_i,
  input  logic [ID_W-1:0] bid_i,
  input  logic [1:0]      bresp_i,
  input  logic            bvalid_i,
  output logic            bready_o
);
  localparam int unsigned TW = $clog2(B_TIMEOUT + 1);
  wr_state_e state_q, state_d;
  logic aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
  logic [TW-1:0] timer_q, timer_d;
  always_comb begin
    state_d = state_q;
    aw_pend_d = aw_pend_q;
    w_pend_d = w_pend_q;
    timer_d = timer_q;
    err_o = 1'b0;
    case (state_q)
      WR_IDLE: if (start_i) begin
        state_d = WR_SEND;
        aw_pend_d = 1'b1;
        w_pend_d = 1'b1;
      end
      WR_SEND: begin
        aw_pend_d = aw_pend_q & ~awready_i;
        w_pend_d = w_pend_q & ~wready_i;
        timer_d = '0;
        if (!aw_pend_d && !w_pend_d) state_d = WR_WAIT_B;
      end
      WR_WAIT_B: begin
        timer_d = timer_q + TW'(1);
        if (bvalid_i) begin
          state_d = WR_DONE;
          err_o = bresp_i != 2'b00 || bid_i != AXI_ID;
        end else if (timer_q == TW'(B_TIMEOUT - 1)) begin
          state_d = WR_DONE;
          err_o = 1'b1;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= WR_IDLE;
      aw_pend_q <= 1'b0;
      w_pend_q <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q <= w_pend_d;
      timer_q <= timer_d;
    end
  end
  assign idle_o = state_q == WR_IDLE;
  assign done_o = state_q == WR_DONE;
  assign bready_o = state_q == WR_WAIT_B;
  assign awvalid_o = aw_pend_q;
  assign wvalid_o = w_pend_q;
endmodule

// File: rtl/hawk_tbl_wr_mngr.sv
// hawk_tbl_wr_mngr: merges one ATT/TOL entry into a 64B table line and writes it back over AXI4.
// Request side: req_vld_i/req_rdy_o with type, 1-based ids, original line and new entries.
// AXI side: single-beat AW/W/B master. done_o pulses once per write; err_o is sticky until reset.
module hawk_tbl_wr_mngr
  import hawk_tbl_wr_mngr_pkg::*;
#(
  parameter int unsigned     ID_W      = 4,
  parameter logic [ID_W-1:0] AXI_ID    = ID_W'('h2),
  parameter int unsigned     B_TIMEOUT = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_vld_i,
  output logic                    req_rdy_o,
  input  logic                    req_type_i,
  input  logic [ATT_ID_W-1:0]     att_id_i,
  input  logic [LST_ID_W-1:0]     lst_id_i,
  input  logic [AXI_DATA_W-1:0]   line_i,
  input  logic [63:0]             att_entry_i,
  input  logic [127:0]            lst_entry_i,
  output logic [ID_W-1:0]         awid_o,
  output logic [AXI_ADDR_W-1:0]   awaddr_o,
  output logic [7:0]              awlen_o,
  output logic [2:0]              awsize_o,
  output logic [1:0]              awburst_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [AXI_DATA_W-1:0]   wdata_o,
  output logic [AXI_DATA_W/8-1:0] wstrb_o,
  output logic                    wlast_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  input  logic [ID_W-1:0]         bid_i,
  input  logic [1:0]              bresp_i,
  input  logic                    bvalid_i,
  output logic                    bready_o,
  output logic                    done_o,
  output logic                    err_o
);
  tbl_wr_reqpkt_t pkt;
  logic accept, wr_idle, wr_err, err_q, err_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [AXI_DATA_W-1:0] line_q, line_d;
  always_comb begin
    accept = req_vld_i & wr_idle;
    pkt = '{typ: tbl_type_e'(req_type_i), att_id: att_id_i, lst_id: lst_id_i,
            att_entry: att_entry_i, lst_entry: lst_entry_i};
    addr_d = accept ? tbl_line_addr(pkt) : addr_q;
    line_d = accept ? merge_tbl_line(line_i, pkt) : line_q;
    err_d = err_q | wr_err;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
      line_q <= '0;
      err_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      line_q <= line_d;
      err_q <= err_d;
    end
  end
  hawk_axi_wr_single #(.ID_W(ID_W), .AXI_ID(AXI_ID), .B_TIMEOUT(B_TIMEOUT)) u_wr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (accept),
    .idle_o    (wr_idle),
    .done_o    (done_o),
    .err_o     (wr_err),
    .awvalid_o (awvalid_o),
    .awready_i (awready_i),
    .wvalid_o  (wvalid_o),
    .wready_i  (wready_i),
    .bid_i     (bid_i),
    .bresp_i   (bresp_i),
    .bvalid_i  (bvalid_i),
    .bready_o  (bready_o)
  );
  assign req_rdy_o = wr_idle;
  assign err_o = err_q;
  assign awid_o = AXI_ID;
  assign awaddr_o = addr_q;
  assign awlen_o = 8'd0;
  assign awsize_o = 3'd6;
  assign awburst_o = 2'b01;
  assign wdata_o = line_q;
  assign wstrb_o = '1;
  assign wlast_o = 1'b1;
endmodule
